// File: rtl/button_events.sv
// Turns a debounced pushbutton level into one-cycle gesture events:
// press, release, click, double-click, long-press and auto-repeat.
module button_events #(
    parameter int CLKPD_NS  = 10,
    parameter int CLKFREQ   = 1_000_000_000 / CLKPD_NS,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in,
    output logic press_p,
    output logic release_p,
    output logic click_p,
    output logic dclick_p,
    output logic long_p,
    output logic rpt_p,
    output logic held
);

    localparam int TICK_CYCLES = CLKFREQ / 1000;
    localparam int MAX_LD      = (LONG_MS > DCLICK_MS) ? LONG_MS : DCLICK_MS;
    localparam int MAX_MS      = (MAX_LD > REPEAT_MS) ? MAX_LD : REPEAT_MS;
    localparam int MS_W        = $clog2(MAX_MS + 1);
    localparam int PRE_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_CYCLES - 1);
    localparam logic [MS_W-1:0]  LONG_LAST   = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0]  DCLICK_LAST = MS_W'(DCLICK_MS - 1);
    localparam logic [MS_W-1:0]  REPEAT_LAST = MS_W'(REPEAT_MS - 1);

    typedef enum logic [2:0] {
        WAIT_LOW,
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    state_t           state_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic             press_q, release_q, click_q, dclick_q, long_q, rpt_q, held_q;
    logic             ms_tick, long_to, dclick_to, rpt_to;

    // A timeout of N ms fires on the edge that would complete the N-th ms.
    always_comb begin
        ms_tick   = (pre_q == PRE_LAST);
        pre_d     = ms_tick ? '0 : pre_q + 1'b1;
        ms_d      = ms_tick ? ms_q + 1'b1 : ms_q;
        long_to   = ms_tick && (ms_q == LONG_LAST);
        dclick_to = ms_tick && (ms_q == DCLICK_LAST);
        rpt_to    = ms_tick && (ms_q == REPEAT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOW;
            pre_q     <= '0;
            ms_q      <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
            pre_q     <= pre_d;
            ms_q      <= ms_d;
            // Input transitions are tested before timeouts so a level change wins a tie.
            case (state_q)
                WAIT_LOW: begin
                    pre_q <= '0;
                    ms_q  <= '0;
                    if (!pb_in) state_q <= IDLE;
                end
                IDLE: begin
                    pre_q <= '0;
                    ms_q  <= '0;
                    if (pb_in) begin
                        state_q <= PRESS1;
                        press_q <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (!pb_in) begin
                        state_q   <= WAIT2;
                        release_q <= 1'b1;
                        pre_q     <= '0;
                        ms_q      <= '0;
                    end else if (long_to) begin
                        state_q <= LONG;
                        long_q  <= 1'b1;
                        held_q  <= 1'b1;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end
                end
                WAIT2: begin
                    if (pb_in) begin
                        state_q <= PRESS2;
                        press_q <= 1'b1;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end else if (dclick_to) begin
                        state_q <= IDLE;
                        click_q <= 1'b1;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end
                end
                PRESS2: begin
                    if (!pb_in) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        dclick_q  <= 1'b1;
                        pre_q     <= '0;
                        ms_q      <= '0;
                    end else if (long_to) begin
                        state_q <= LONG;
                        long_q  <= 1'b1;
                        held_q  <= 1'b1;
                        pre_q   <= '0;
                        ms_q    <= '0;
                    end
                end
                LONG: begin
                    if (!pb_in) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        pre_q     <= '0;
                        ms_q      <= '0;
                    end else if (rpt_to) begin
                        rpt_q <= 1'b1;
                        pre_q <= '0;
                        ms_q  <= '0;
                    end
                end
                default: begin
                    state_q <= WAIT_LOW;
                    held_q  <= 1'b0;
                    pre_q   <= '0;
                    ms_q    <= '0;
                end
            endcase
        end
    end

    assign press_p   = press_q;
    assign release_p = release_q;
    assign click_p   = click_q;
    assign dclick_p  = dclick_q;
    assign long_p    = long_q;
    assign rpt_p     = rpt_q;
    assign held      = held_q;

endmodule

// File: doc/button_events.md
# button_events

Classifies the debounced pushbutton level into single-cycle user events: press, release, click, double-click, long-press and auto-repeat. Sits directly downstream of the pushbutton debouncer. Its pulses drive the queue control logic in place of raw edge detection. `pb_in` is already synchronous and bounce-free, so the block adds no synchronizer.

## Interface

Parameters:
- `CLKPD_NS`, 10: clock period in ns.
- `CLKFREQ`, 1_000_000_000/CLKPD_NS: clock frequency in Hz.
- `LONG_MS`, 1000: hold time that qualifies a long press; must be ≥1.
- `DCLICK_MS`, 300: window after a release in which a second press makes a double-click; must be ≥1.
- `REPEAT_MS`, 200: auto-repeat interval while long-held; must be ≥1.
- localparam `TICK_CYCLES` = CLKFREQ/1000: cycles per ms; must be ≥1.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pb_in` in 1: debounced button level, 1 = pressed.
- `press_p` out 1: one-cycle pulse on an accepted press.
- `release_p` out 1: one-cycle pulse on release.
- `click_p` out 1: one-cycle pulse when a single short click is confirmed.
- `dclick_p` out 1: one-cycle pulse on a completed double-click.
- `long_p` out 1: one-cycle pulse when a hold reaches LONG_MS.
- `rpt_p` out 1: one-cycle pulse every REPEAT_MS while long-held.
- `held` out 1: level, high while in LONG.

## Operation

- Datapath:
  - ms prescaler, 0..TICK_CYCLES-1.
  - ms counter, width $clog2(max(LONG_MS,DCLICK_MS,REPEAT_MS)+1).
  - Both clear on every state transition and on every repeat, so intervals are exact from the entry edge.
- FSM states: WAIT_LOW, IDLE, PRESS1, WAIT2, PRESS2, LONG.
- WAIT_LOW:
  - Reset state.
  - `pb_in`=0 → IDLE.
  - A button held through reset produces no events.
- IDLE:
  - `pb_in`=1 → PRESS1, `press_p`.
- PRESS1:
  - `pb_in`=0 → WAIT2, `release_p`.
  - Elapsed LONG_MS → LONG, `long_p`.
- WAIT2:
  - `pb_in`=1 → PRESS2, `press_p`.
  - Elapsed DCLICK_MS → IDLE, `click_p`.
- PRESS2:
  - `pb_in`=0 → IDLE, `release_p` and `dclick_p` together.
  - Elapsed LONG_MS → LONG, `long_p`; no `dclick_p` or `click_p` follows.
- LONG:
  - Every elapsed REPEAT_MS → `rpt_p`, counters clear.
  - `pb_in`=0 → IDLE, `release_p`; no click or dclick.
- Simultaneous events: an input level change and a timeout on the same edge → the input transition wins.
  - PRESS1 release at exactly LONG_MS gives WAIT2, no `long_p`.
  - WAIT2 press at exactly DCLICK_MS gives PRESS2, no `click_p`.
- Mutual exclusion: at most one of `click_p`, `dclick_p`, `long_p` per gesture. `press_p` and `rpt_p` never coincide.
- Reset mid-operation:
  - All outputs go to 0 immediately (async); FSM returns to WAIT_LOW.
  - No pending click or dclick is emitted after reset.

## Timing

- All outputs are registered. Reset value of every output is 0.
- Input-driven events: output asserted from the first rising edge at which `pb_in` is sampled at the new level (edge E), for exactly one cycle. Latency: 1 edge from `pb_in` change to pulse.
- Timeouts: state entered at edge E with interval N ms fires at edge E + N·TICK_CYCLES.
- Repeats: `rpt_p` at long edge L + k·REPEAT_MS·TICK_CYCLES, k ≥ 1.
- `held`: high from the `long_p` edge; low from the edge that samples `pb_in`=0 in LONG.
- No counter wrap: every timeout clears the counters before they can overflow.

## Test plan

Bench parameters for all scenarios: CLKFREQ=10_000 (TICK_CYCLES=10), LONG_MS=5, DCLICK_MS=3, REPEAT_MS=2.

1. Reset release with `pb_in`=1, hold 100 cycles, drop, raise at edge P → no outputs during the hold; `press_p` at P only.
2. Press at P, hold 20 cycles, release sampled at F=P+20 → `press_p`@P, `release_p`@F, `click_p`@F+30, no `dclick_p`/`long_p`.
3. High 20, low 15, high 20, low (second release at F2) → two `press_p`, two `release_p`, `dclick_p`@F2, no `click_p` ever.
4. Press at P, hold 120 cycles, release at P+120 → `long_p`@P+50; `rpt_p`@P+70, P+90, P+110; `held` high P+50..P+119; `release_p`@P+120; no `click_p`.
5. Boundary cases:
   - Release sampled exactly at P+50 → `release_p`, no `long_p`.
   - Then re-press sampled exactly 30 cycles later → `press_p`, no `click_p`.
6. In LONG with `held`=1, pulse `rst_n` low mid-cycle while `pb_in` stays 1 → all outputs 0 asynchronously. After `rst_n` returns high, no events until `pb_in` drops and rises again.
